oflow_conflict_resolve: RTL and testbench

- Sits directly downstream of the registration stage's score board and consumes `score_to_cr` / `id_to_cr`.
- Walks the score-board rows of the current frame and makes every previous-frame ID claimed by at most one current object.
- The row with the lower score wins. A displaced row retries its second candidate; if that fails, the row is flagged as a new object.
- Results go back to the score board through the pointer-write port (`row_to_change`, `write_to_pointer`, `data_from_cr`).

---
 rtl/oflow_conflict_resolve.sv | 187 ++++++++++++++++++
 tb/tb_oflow_conflict_resolve.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_conflict_resolve.sv
// Conflict resolution for the optical-flow score board: makes each previous-frame ID owned by
// at most one current row, retrying a displaced row once on its second candidate.
module oflow_conflict_resolve #(
    parameter int unsigned ROWS      = 32,
    parameter int unsigned ROW_LEN   = 5,
    parameter int unsigned ID_LEN    = 7,
    parameter int unsigned SCORE_LEN = 16
) (
    input  logic                   clk,
    input  logic                   reset_N,
    input  logic                   start_cr,
    input  logic [ROW_LEN:0]       num_of_rows,
    input  logic [2*SCORE_LEN-1:0] score_to_cr,
    input  logic [2*ID_LEN-1:0]    id_to_cr,
    output logic [ROW_LEN-1:0]     row_sel_from_cr,
    output logic [ROW_LEN-1:0]     row_to_change,
    output logic                   write_to_pointer,
    output logic                   data_from_cr,
    output logic [ROWS-1:0]        new_obj,
    output logic                   busy_cr,
    output logic                   done_cr
);

    localparam int unsigned NumIds = 2**ID_LEN;

    typedef enum logic [2:0] {
        StIdle, StClear, StRead, StEval, StRdDisp, StEvalDisp, StDone
    } state_e;

    state_e               state_q, state_d;
    logic [ROW_LEN:0]     r_q, r_d, num_q, num_d, r_inc;
    logic [ROW_LEN-1:0]   d_q, d_d;
    logic                 dch_q, dch_d;
    logic [ROWS-1:0]      new_obj_q, new_obj_d;
    logic                 advance;

    // Ownership table: only the valid bits need reset; payload is qualified by them.
    logic [NumIds-1:0]    tbl_valid_q;
    logic [ROW_LEN-1:0]   tbl_owner_q  [NumIds];
    logic [SCORE_LEN-1:0] tbl_score_q  [NumIds];
    logic                 tbl_choice_q [NumIds];

    logic                 clear_tbl, tbl_we, tbl_wchoice;
    logic [ID_LEN-1:0]    tbl_widx;
    logic [ROW_LEN-1:0]   tbl_wowner;
    logic [SCORE_LEN-1:0] tbl_wscore;

    logic [SCORE_LEN-1:0] score0, score1, lk_score;
    logic [ID_LEN-1:0]    id0, id1, lk_id;
    logic [ROW_LEN-1:0]   lk_owner;
    logic                 lk_valid, lk_choice;

    assign score0 = score_to_cr[2*SCORE_LEN-1:SCORE_LEN];
    assign score1 = score_to_cr[SCORE_LEN-1:0];
    assign id0    = id_to_cr[2*ID_LEN-1:ID_LEN];
    assign id1    = id_to_cr[ID_LEN-1:0];

    assign lk_id     = (state_q == StEvalDisp) ? id1 : id0;
    assign lk_valid  = tbl_valid_q[lk_id];
    assign lk_owner  = tbl_owner_q[lk_id];
    assign lk_score  = tbl_score_q[lk_id];
    assign lk_choice = tbl_choice_q[lk_id];

    assign r_inc = r_q + (ROW_LEN+1)'(1);

    always_comb begin
        state_d          = state_q;
        r_d              = r_q;
        num_d            = num_q;
        d_d              = d_q;
        dch_d            = dch_q;
        new_obj_d        = new_obj_q;
        clear_tbl        = 1'b0;
        tbl_we           = 1'b0;
        tbl_widx         = lk_id;
        tbl_wowner       = r_q[ROW_LEN-1:0];
        tbl_wscore       = score0;
        tbl_wchoice      = 1'b0;
        write_to_pointer = 1'b0;
        advance          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_cr) begin
                    num_d     = num_of_rows;
                    r_d       = '0;
                    new_obj_d = '0;
                    state_d   = StClear;
                end
            end
            StClear: begin
                clear_tbl = 1'b1;
                state_d   = (num_q == '0) ? StDone : StRead;
            end
            StRead: state_d = StEval;
            StEval: begin
                if (!lk_valid) begin
                    tbl_we  = 1'b1;
                    advance = 1'b1;
                end else if (score0 < lk_score) begin
                    tbl_we  = 1'b1;
                    d_d     = lk_owner;
                    dch_d   = lk_choice;
                    state_d = StRdDisp;
                end else begin
                    // Ties keep the incumbent; the current row becomes the displaced one.
                    d_d     = r_q[ROW_LEN-1:0];
                    dch_d   = 1'b0;
                    state_d = StRdDisp;
                end
            end
            StRdDisp: begin
                if (dch_q) begin
                    new_obj_d[d_q] = 1'b1;
                    advance        = 1'b1;
                end else begin
                    state_d = StEvalDisp;
                end
            end
            StEvalDisp: begin
                if (!lk_valid) begin
                    tbl_we           = 1'b1;
                    tbl_wowner       = d_q;
                    tbl_wscore       = score1;
                    tbl_wchoice      = 1'b1;
                    write_to_pointer = 1'b1;
                end else begin
                    new_obj_d[d_q] = 1'b1;
                end
                advance = 1'b1;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (advance) begin
            r_d     = r_inc;
            state_d = (r_inc == num_q) ? StDone : StRead;
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= StIdle;
            r_q         <= '0;
            num_q       <= '0;
            d_q         <= '0;
            dch_q       <= 1'b0;
            new_obj_q   <= '0;
            tbl_valid_q <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            num_q     <= num_d;
            d_q       <= d_d;
            dch_q     <= dch_d;
            new_obj_q <= new_obj_d;
            if (clear_tbl) begin
                tbl_valid_q <= '0;
            end else if (tbl_we) begin
                tbl_valid_q[tbl_widx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_owner_q[tbl_widx]  <= tbl_wowner;
            tbl_score_q[tbl_widx]  <= tbl_wscore;
            tbl_choice_q[tbl_widx] <= tbl_wchoice;
        end
    end

    always_comb begin
        row_sel_from_cr = '0;
        unique case (state_q)
            StRead, StEval:        row_sel_from_cr = r_q[ROW_LEN-1:0];
            StRdDisp, StEvalDisp:  row_sel_from_cr = d_q;
            default:               row_sel_from_cr = '0;
        endcase
    end

    assign row_to_change = write_to_pointer ? d_q : '0;
    assign data_from_cr  = write_to_pointer;
    assign new_obj       = new_obj_q;
    assign busy_cr       = (state_q != StIdle) && (state_q != StDone);
    assign done_cr       = (state_q == StDone);

endmodule

// File: tb/tb_oflow_conflict_resolve.sv
// Scoreboard bench: a frame-level reference model predicts pointer writes, new_obj and
// completion latency; a negedge monitor checks them as the DUT produces them.
module tb_oflow_conflict_resolve;

    localparam int ROWS = 32, ROW_LEN = 5, ID_LEN = 7, SCORE_LEN = 16;

    logic                   clk = 1'b0;
    logic                   reset_N = 1'b0;
    logic                   start_cr = 1'b0;
    logic [ROW_LEN:0]       num_of_rows = '0;
    logic [2*SCORE_LEN-1:0] score_to_cr = '0;
    logic [2*ID_LEN-1:0]    id_to_cr = '0;
    logic [ROW_LEN-1:0]     row_sel_from_cr, row_to_change;
    logic                   write_to_pointer, data_from_cr, busy_cr, done_cr;
    logic [ROWS-1:0]        new_obj;

    oflow_conflict_resolve #(
        .ROWS(ROWS), .ROW_LEN(ROW_LEN), .ID_LEN(ID_LEN), .SCORE_LEN(SCORE_LEN)
    ) dut (
        .clk(clk), .reset_N(reset_N), .start_cr(start_cr), .num_of_rows(num_of_rows),
        .score_to_cr(score_to_cr), .id_to_cr(id_to_cr), .row_sel_from_cr(row_sel_from_cr),
        .row_to_change(row_to_change), .write_to_pointer(write_to_pointer),
        .data_from_cr(data_from_cr), .new_obj(new_obj), .busy_cr(busy_cr), .done_cr(done_cr)
    );

    always #5 clk = ~clk;

    // Score-board contents, one-cycle read latency
    int sb_id0 [ROWS], sb_id1 [ROWS], sb_s0 [ROWS], sb_s1 [ROWS];
    int ptr_mem [ROWS];
    always @(posedge clk) begin
        score_to_cr <= {SCORE_LEN'(sb_s0[row_sel_from_cr]), SCORE_LEN'(sb_s1[row_sel_from_cr])};
        id_to_cr    <= {ID_LEN'(sb_id0[row_sel_from_cr]), ID_LEN'(sb_id1[row_sel_from_cr])};
    end

    typedef struct { logic [ROWS-1:0] nobj; int cycles; } done_exp_t;
    int        exp_wr_q [$];
    done_exp_t exp_done_q [$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0, done_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_N) begin
            if (write_to_pointer) begin
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    chk("wr_row", 64'(row_to_change), 64'(exp_wr_q.pop_front()));
                    chk("wr_data", 64'(data_from_cr), 64'd1);
                end
                ptr_mem[row_to_change] = int'(data_from_cr);
            end
            if (done_cr) begin
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    done_exp_t e;
                    e = exp_done_q.pop_front();
                    chk("new_obj", 64'(new_obj), 64'(e.nobj));
                    chk("done_latency", 64'(cyc - start_cyc), 64'(e.cycles));
                    chk("writes_pending", 64'(exp_wr_q.size()), 64'd0);
                    chk("busy_at_done", 64'(busy_cr), 64'd0);
                end
                done_cnt++;
            end
        end
    end

    // Reference: walk rows in order, lowest score owns an ID, one retry on id1
    task automatic model_frame(input int n);
        bit        ov [128];
        int        orow [128];
        int        oscore [128];
        bit        och [128];
        done_exp_t e;
        int        id, d;
        bit        dch;
        e.nobj = '0;
        e.cycles = 2;
        for (int r = 0; r < n; r++) begin
            id = sb_id0[r];
            if (!ov[id]) begin
                ov[id] = 1; orow[id] = r; oscore[id] = sb_s0[r]; och[id] = 0;
                e.cycles += 2;
                continue;
            end
            if (sb_s0[r] < oscore[id]) begin
                d = orow[id]; dch = och[id];
                orow[id] = r; oscore[id] = sb_s0[r]; och[id] = 0;
            end else begin
                d = r; dch = 0;
            end
            if (dch) begin
                e.nobj[d] = 1'b1;
                e.cycles += 3;
                continue;
            end
            e.cycles += 4;
            id = sb_id1[d];
            if (!ov[id]) begin
                ov[id] = 1; orow[id] = d; oscore[id] = sb_s1[d]; och[id] = 1;
                exp_wr_q.push_back(d);
            end else begin
                e.nobj[d] = 1'b1;
            end
        end
        exp_done_q.push_back(e);
    endtask

    task automatic set_row(input int r, input int i0, input int s0, input int i1, input int s1);
        sb_id0[r] = i0; sb_s0[r] = s0; sb_id1[r] = i1; sb_s1[r] = s1;
    endtask

    task automatic pulse_start(input int n, input bit extra);
        for (int i = 0; i < ROWS; i++) ptr_mem[i] = 0;
        @(posedge clk); #1;
        num_of_rows = (ROW_LEN+1)'(n);
        start_cr = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start_cr = 1'b0;
        chk("busy_after_start", 64'(busy_cr), 64'd1);
        if (extra) begin
            @(posedge clk); @(posedge clk); #1;
            num_of_rows = (ROW_LEN+1)'($urandom_range(1, ROWS));
            start_cr = 1'b1;
            @(posedge clk); #1;
            start_cr = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 400) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt < target) begin
            chk("done_timeout", 64'd0, 64'd1);
            exp_wr_q.delete();
            exp_done_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int n, input bit extra);
        model_frame(n);
        pulse_start(n, extra);
        wait_done(done_cnt + 1);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_outputs"}, 64'({row_sel_from_cr, row_to_change, write_to_pointer,
                                    data_from_cr, busy_cr, done_cr}), 64'd0);
        chk({tag, "_new_obj"}, 64'(new_obj), 64'd0);
    endtask

    task automatic load_no_conflict();
        set_row(0, 5, 10, 20, 10);
        set_row(1, 6, 10, 21, 10);
        set_row(2, 7, 10, 22, 10);
    endtask

    initial begin
        for (int i = 0; i < ROWS; i++) set_row(i, 0, 0, 0, 0);
        #12;
        check_idle_zero("reset");
        reset_N = 1'b1;

        // 1: no conflicts
        load_no_conflict();
        run_frame(3, 1'b0);
        // 2: steal, displaced row falls back to id1
        set_row(0, 4, 100, 9, 30);
        set_row(1, 4, 40, 10, 30);
        run_frame(2, 1'b0);
        chk("steal_ptr_row0", 64'(ptr_mem[0]), 64'd1);
        // 3: tie keeps incumbent; row1 id1 already taken
        set_row(0, 3, 50, 11, 50);
        set_row(1, 3, 50, 3, 50);
        run_frame(2, 1'b0);
        chk("tie_held_new_obj", 64'(new_obj), 64'd2);
        // 4: second-choice holder displaced
        set_row(0, 2, 10, 8, 60);
        set_row(1, 2, 20, 8, 50);
        set_row(2, 8, 5, 12, 60);
        run_frame(3, 1'b0);
        chk("disp2_ptr_row1", 64'(ptr_mem[1]), 64'd1);
        // 5: empty frame
        run_frame(0, 1'b0);
        // 6: reset during EVAL_DISP of a steal frame, then a clean frame
        set_row(0, 4, 100, 9, 30);
        set_row(1, 4, 40, 10, 30);
        pulse_start(2, 1'b0);
        repeat (6) @(posedge clk);
        #2 reset_N = 1'b0;
        @(negedge clk);
        check_idle_zero("mid_reset");
        @(posedge clk); #1 reset_N = 1'b1;
        load_no_conflict();
        run_frame(3, 1'b0);

        // randomized frames with dense ID collisions and frequent score ties
        for (int f = 0; f < 30; f++) begin
            int n;
            n = (f % 7 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, ROWS));
            for (int r = 0; r < ROWS; r++) begin
                int a, b;
                a = (f % 5 == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 11));
                b = ($urandom_range(0, 7) == 0) ? a : int'($urandom_range(0, 15));
                set_row(r, a, int'($urandom_range(0, 40)), b, int'($urandom_range(0, 40)));
            end
            run_frame(n, (f % 2 == 1) && (n >= 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
